// File: rtl/mutex_client_2.sv
// Two-channel requester front end for a clocked 2-way mutex: acquires, qualifies
// the grant, holds the resource for a job length, releases and flags misuse.
module mutex_client_2 #(
    parameter int LEN_W      = 8,
    parameter int STABLE_CYC = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       start,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic [1:0]       req,
    input  logic [1:0]       gnt,
    output logic [1:0]       busy,
    output logic [1:0]       own,
    output logic [1:0]       done,
    output logic [1:0]       timeout,
    output logic             excl_err
);

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [3:0]       STAB_LIM = 4'(STABLE_CYC);
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_ACQ, S_OWN, S_REL} state_t;

    state_t           r_state [2];
    state_t           w_state_nxt [2];
    logic [3:0]       r_stab [2];
    logic [3:0]       w_stab_nxt [2];
    logic [TO_W-1:0]  r_to [2];
    logic [TO_W-1:0]  w_to_nxt [2];
    logic [LEN_W-1:0] r_len [2];
    logic [LEN_W-1:0] w_len_nxt [2];
    logic [LEN_W-1:0] w_len_in [2];
    logic [1:0]       r_ok, w_ok_nxt;
    logic [1:0]       r_req, r_busy, r_own, r_done, r_timeout;
    logic [1:0]       w_done, w_tout, w_err;
    logic             w_err_any;
    logic             r_excl;

    assign w_len_in[0] = len0;
    assign w_len_in[1] = len1;

    always_comb begin
        w_done   = '0;
        w_tout   = '0;
        w_err    = '0;
        w_ok_nxt = r_ok;
        for (int i = 0; i < 2; i++) begin
            w_state_nxt[i] = r_state[i];
            w_stab_nxt[i]  = r_stab[i];
            w_to_nxt[i]    = r_to[i];
            w_len_nxt[i]   = r_len[i];
            case (r_state[i])
                S_IDLE: begin
                    if (gnt[i]) w_err[i] = 1'b1;
                    if (start[i]) begin
                        w_state_nxt[i] = S_ACQ;
                        w_len_nxt[i]   = (w_len_in[i] == '0) ? LEN_ONE : w_len_in[i];
                        w_stab_nxt[i]  = '0;
                        w_to_nxt[i]    = '0;
                        w_ok_nxt[i]    = 1'b0;
                    end
                end
                S_ACQ: begin
                    if (gnt[i] && !gnt[1-i])
                        w_stab_nxt[i] = (r_stab[i] != STAB_LIM) ? r_stab[i] + 4'd1 : r_stab[i];
                    else
                        w_stab_nxt[i] = '0;
                    if (r_to[i] != TO_LIM) w_to_nxt[i] = r_to[i] + 1'b1;
                    // Qualification beats timeout; the other channel's own must already be low.
                    if (r_stab[i] == STAB_LIM && !r_own[1-i]) begin
                        w_state_nxt[i] = S_OWN;
                    end else if (TIMEOUT != 0 && w_to_nxt[i] == TO_LIM) begin
                        w_state_nxt[i] = S_REL;
                        w_tout[i]      = 1'b1;
                    end
                end
                S_OWN: begin
                    if (!gnt[i]) begin
                        w_state_nxt[i] = S_REL;
                        w_err[i]       = 1'b1;
                    end else if (r_len[i] == LEN_ONE) begin
                        w_state_nxt[i] = S_REL;
                        w_ok_nxt[i]    = 1'b1;
                    end else begin
                        w_len_nxt[i] = r_len[i] - LEN_ONE;
                    end
                end
                S_REL: begin
                    if (!gnt[i]) begin
                        w_state_nxt[i] = S_IDLE;
                        w_done[i]      = r_ok[i];
                    end
                end
                default: w_state_nxt[i] = S_IDLE;
            endcase
        end
    end

    assign w_err_any = (w_err != 2'b00) || (gnt == 2'b11);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= S_IDLE;
                r_stab[i]  <= '0;
                r_to[i]    <= '0;
                r_len[i]   <= '0;
            end
            r_ok      <= '0;
            r_req     <= '0;
            r_busy    <= '0;
            r_own     <= '0;
            r_done    <= '0;
            r_timeout <= '0;
            r_excl    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_stab[i]  <= w_stab_nxt[i];
                r_to[i]    <= w_to_nxt[i];
                r_len[i]   <= w_len_nxt[i];
                r_req[i]   <= (w_state_nxt[i] == S_ACQ) || (w_state_nxt[i] == S_OWN);
                r_busy[i]  <= (w_state_nxt[i] != S_IDLE);
                r_own[i]   <= (w_state_nxt[i] == S_OWN);
            end
            r_ok      <= w_ok_nxt;
            r_done    <= w_done;
            r_timeout <= w_tout;
            r_excl    <= r_excl | w_err_any;
        end
    end

    assign req      = r_req;
    assign busy     = r_busy;
    assign own      = r_own;
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign excl_err = r_excl;

endmodule

// File: tb/tb_mutex_client_2.sv
// Directed bench for mutex_client_2: hand-timed grant sequences against a
// STABLE_CYC=2 instance (TIMEOUT=255) and a TIMEOUT=10 instance.
module tb_mutex_client_2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start, gnt;
    logic [7:0] len0, len1;
    logic [1:0] req, busy, own, done, timeout;
    logic       excl_err;
    logic [1:0] t_req, t_busy, t_own, t_done, t_timeout;
    logic       t_excl;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    mutex_client_2 #(.LEN_W(8), .STABLE_CYC(2), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len0(len0), .len1(len1),
        .req(req), .gnt(gnt), .busy(busy), .own(own), .done(done),
        .timeout(timeout), .excl_err(excl_err)
    );

    mutex_client_2 #(.LEN_W(8), .STABLE_CYC(2), .TIMEOUT(10)) u_to (
        .clk(clk), .rst_n(rst_n), .start(start), .len0(len0), .len1(len1),
        .req(t_req), .gnt(gnt), .busy(t_busy), .own(t_own), .done(t_done),
        .timeout(t_timeout), .excl_err(t_excl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 2'b00;
        gnt   = 2'b00;
        len0  = 8'd0;
        len1  = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_req", req, 2'b00);
        chk("rst_busy", busy, 2'b00);
        chk("rst_own", own, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_timeout", timeout, 2'b00);
        chk("rst_excl", {1'b0, excl_err}, 2'b00);

        // single job, len0=4
        start = 2'b01; len0 = 8'd4;
        tick();                                   // N
        start = 2'b00;
        chk("s_req_N", req, 2'b01);
        chk("s_busy_N", busy, 2'b01);
        tick();                                   // N+1
        gnt = 2'b01;
        chk("s_own_N1", own, 2'b00);
        tick(); chk("s_own_N2", own, 2'b00);
        tick(); chk("s_own_N3", own, 2'b00);
        for (int k = 0; k < 4; k++) begin         // N+4..N+7
            tick();
            chk("s_own_hold", own, 2'b01);
            chk("s_req_hold", req, 2'b01);
        end
        tick();                                   // N+8
        chk("s_own_end", own, 2'b00);
        chk("s_req_rel", req, 2'b00);
        chk("s_busy_rel", busy, 2'b01);
        chk("s_done_rel", done, 2'b00);
        gnt = 2'b00;
        tick();                                   // N+9
        chk("s_done", done, 2'b01);
        chk("s_busy_idle", busy, 2'b00);
        tick();
        chk("s_done_pulse", done, 2'b00);
        chk("s_excl", {1'b0, excl_err}, 2'b00);

        // contention: ch1 granted first
        do_reset();
        tick();
        start = 2'b11; len0 = 8'd3; len1 = 8'd5;
        tick();                                   // N
        start = 2'b00;
        chk("c_req_N", req, 2'b11);
        tick();                                   // N+1
        gnt = 2'b10;
        tick(); chk("c_own_N2", own, 2'b00);
        tick(); chk("c_own_N3", own, 2'b00);
        for (int k = 0; k < 5; k++) begin         // N+4..N+8
            tick();
            chk("c_own1", own, 2'b10);
        end
        tick();                                   // N+9
        chk("c_own1_end", own, 2'b00);
        chk("c_req_rel1", req, 2'b01);
        gnt = 2'b00;
        tick();                                   // N+10
        chk("c_done1", done, 2'b10);
        chk("c_busy_after1", busy, 2'b01);
        gnt = 2'b01;
        tick();                                   // N+11
        chk("c_done1_pulse", done, 2'b00);
        chk("c_own_N11", own, 2'b00);
        tick(); chk("c_own_N12", own, 2'b00);
        for (int k = 0; k < 3; k++) begin         // N+13..N+15
            tick();
            chk("c_own0", own, 2'b01);
        end
        tick();                                   // N+16
        chk("c_own0_end", own, 2'b00);
        chk("c_req_rel0", req, 2'b00);
        gnt = 2'b00;
        tick();                                   // N+17
        chk("c_done0", done, 2'b01);
        chk("c_busy_idle", busy, 2'b00);
        chk("c_excl", {1'b0, excl_err}, 2'b00);

        // glitchy grant 1,0,1,1
        do_reset();
        tick();
        start = 2'b01; len0 = 8'd2;
        tick();                                   // N
        start = 2'b00;
        tick(); gnt = 2'b01;                      // N+1
        tick(); gnt = 2'b00; chk("g_own_N2", own, 2'b00);
        tick(); gnt = 2'b01; chk("g_own_N3", own, 2'b00);
        tick(); chk("g_own_N4", own, 2'b00);
        tick(); chk("g_own_N5", own, 2'b00);
        tick(); chk("g_own_N6", own, 2'b01);
        tick(); chk("g_own_N7", own, 2'b01);
        tick(); chk("g_own_N8", own, 2'b00);
        gnt = 2'b00;
        tick(); chk("g_done", done, 2'b01);

        // timeout on the TIMEOUT=10 instance
        do_reset();
        tick();
        start = 2'b01; len0 = 8'd4;
        tick();                                   // N
        start = 2'b00;
        repeat (9) tick();                        // N+9
        chk("t_req_N9", t_req, 2'b01);
        chk("t_to_N9", t_timeout, 2'b00);
        tick();                                   // N+10
        chk("t_to_pulse", t_timeout, 2'b01);
        chk("t_req_drop", t_req, 2'b00);
        chk("t_busy_rel", t_busy, 2'b01);
        tick();                                   // N+11
        chk("t_to_clear", t_timeout, 2'b00);
        chk("t_no_done", t_done, 2'b00);
        chk("t_busy_idle", t_busy, 2'b00);
        start = 2'b01;
        tick();
        start = 2'b00;
        chk("t_restart_req", t_req, 2'b01);
        chk("t_restart_busy", t_busy, 2'b01);

        // gnt=11 during ACQ
        do_reset();
        tick();
        start = 2'b01; len0 = 8'd2;
        tick();
        start = 2'b00;
        chk("e_excl_pre", {1'b0, excl_err}, 2'b00);
        tick(); gnt = 2'b11;
        tick(); gnt = 2'b00;
        chk("e_excl_set", {1'b0, excl_err}, 2'b01);
        repeat (3) tick();
        chk("e_excl_sticky", {1'b0, excl_err}, 2'b01);

        // grant loss mid-OWN on ch1
        do_reset();
        tick();
        start = 2'b10; len1 = 8'd5;
        tick();                                   // N
        start = 2'b00;
        tick(); gnt = 2'b10;                      // N+1
        repeat (3) tick();                        // N+4
        chk("l_own_N4", own, 2'b10);
        tick();                                   // N+5
        chk("l_own_N5", own, 2'b10);
        chk("l_excl_pre", {1'b0, excl_err}, 2'b00);
        gnt = 2'b00;
        tick();                                   // N+6
        chk("l_own_drop", own, 2'b00);
        chk("l_excl", {1'b0, excl_err}, 2'b01);
        chk("l_req", req, 2'b00);
        tick();                                   // N+7
        chk("l_no_done", done, 2'b00);
        chk("l_busy_idle", busy, 2'b00);

        // async reset mid-OWN
        do_reset();
        tick();
        start = 2'b01; len0 = 8'd6;
        tick();                                   // N
        start = 2'b00;
        tick(); gnt = 2'b01;                      // N+1
        repeat (4) tick();                        // N+5
        chk("a_own_pre", own, 2'b01);
        #3 rst_n = 1'b0;
        #1;
        chk("a_req", req, 2'b00);
        chk("a_own", own, 2'b00);
        chk("a_busy", busy, 2'b00);
        chk("a_done", done, 2'b00);
        chk("a_timeout", timeout, 2'b00);
        gnt = 2'b00;
        #1 rst_n = 1'b1;
        tick();
        start = 2'b01; len0 = 8'd1;
        tick();                                   // N
        start = 2'b00;
        chk("a_restart_req", req, 2'b01);
        chk("a_restart_busy", busy, 2'b01);
        tick(); gnt = 2'b01;                      // N+1
        repeat (3) tick();                        // N+4
        chk("a_own_len1", own, 2'b01);
        tick();                                   // N+5
        chk("a_own_end", own, 2'b00);
        gnt = 2'b00;
        tick();                                   // N+6
        chk("a_done_end", done, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
